// File: rtl/lsu_byte_sequencer.sv
// +----------------------------------------------------------------------------+
// | lsu_byte_sequencer: splits RV32I loads/stores into little-endian byte      |
// | accesses on a byte-wide data memory. Rev 1.0                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module lsu_byte_sequencer #(
  parameter int AW   = 8,
  parameter int XLEN = 32
) (
  input  logic            Clk,
  input  logic            n_Rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy,
  output logic            mem_we,
  output logic [AW-1:0]   mem_a,
  output logic [7:0]      mem_wd,
  input  logic [7:0]      mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;

  state_t          r_state;
  logic [AW-1:0]   r_base;
  logic            r_we;
  logic            r_unsigned;
  logic [1:0]      r_size;
  logic [1:0]      r_cnt;
  logic [1:0]      r_last;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_data;
  logic            r_rsp_valid;
  logic            r_rsp_err;
  logic [XLEN-1:0] r_rsp_rdata;

  logic            w_range_err;
  logic            w_req_err;
  logic [1:0]      w_req_last;
  logic [XLEN-1:0] w_data_next;
  logic [XLEN-1:0] w_ext;
  logic [7:0]      w_wd_byte;
  logic            w_in_xfer;

  assign w_range_err = |req_addr[XLEN-1:AW];

  always_comb begin
    w_req_err  = 1'b0;
    w_req_last = 2'd0;
    case (req_size)
      c_SIZE_BYTE: w_req_last = 2'd0;
      c_SIZE_HALF: begin
        w_req_err  = req_addr[0];
        w_req_last = 2'd1;
      end
      c_SIZE_WORD: begin
        w_req_err  = |req_addr[1:0];
        w_req_last = 2'd3;
      end
      default: w_req_err = 1'b1;
    endcase
    w_req_err = w_req_err | w_range_err;
  end

  // Load data including the byte arriving this cycle, so the final byte is
  // visible to the extension logic on the same edge it is captured.
  always_comb begin
    w_data_next = r_data;
    case (r_cnt)
      2'd0:    w_data_next[7:0]   = mem_rd;
      2'd1:    w_data_next[15:8]  = mem_rd;
      2'd2:    w_data_next[23:16] = mem_rd;
      default: w_data_next[31:24] = mem_rd;
    endcase
  end

  always_comb begin
    w_ext = w_data_next;
    case (r_size)
      c_SIZE_BYTE: w_ext = {{(XLEN-8){~r_unsigned & w_data_next[7]}}, w_data_next[7:0]};
      c_SIZE_HALF: w_ext = {{(XLEN-16){~r_unsigned & w_data_next[15]}}, w_data_next[15:0]};
      default:     w_ext = w_data_next;
    endcase
  end

  always_comb begin
    w_wd_byte = r_wdata[7:0];
    case (r_cnt)
      2'd0:    w_wd_byte = r_wdata[7:0];
      2'd1:    w_wd_byte = r_wdata[15:8];
      2'd2:    w_wd_byte = r_wdata[23:16];
      default: w_wd_byte = r_wdata[31:24];
    endcase
  end

  // Memory side is decoded purely from registered state.
  assign w_in_xfer = (r_state == S_XFER);
  assign mem_we    = w_in_xfer & r_we;
  assign mem_a     = w_in_xfer ? (r_base + AW'(r_cnt)) : '0;
  assign mem_wd    = w_in_xfer ? w_wd_byte : 8'h00;

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

  always_ff @(posedge Clk or negedge n_Rst) begin
    if (!n_Rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= 2'b00;
      r_cnt       <= 2'd0;
      r_last      <= 2'd0;
      r_wdata     <= '0;
      r_data      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_req_err) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state    <= S_XFER;
              r_base     <= req_addr[AW-1:0];
              r_we       <= req_we;
              r_unsigned <= req_unsigned;
              r_size     <= req_size;
              r_last     <= w_req_last;
              r_wdata    <= req_wdata;
              r_data     <= '0;
              r_cnt      <= 2'd0;
            end
          end
        end
        S_XFER: begin
          if (!r_we) begin
            r_data <= w_data_next;
          end
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == r_last) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_we ? '0 : w_ext;
          end
        end
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_byte_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_lsu_byte_sequencer: directed and random load/store requests against a   |
// | byte-level reference model. Rev 1.0                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_lsu_byte_sequencer;

  localparam int AW = 8;
  localparam int DEPTH = 1 << AW;

  logic        Clk;
  logic        n_Rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mem_we;
  logic [AW-1:0] mem_a;
  logic [7:0]  mem_wd;
  logic [7:0]  mem_rd;

  logic        mem_fill;
  logic [7:0]  tb_mem  [0:DEPTH-1];
  logic [7:0]  ref_mem [0:DEPTH-1];

  int vectors;
  int miscompares;

  lsu_byte_sequencer #(.AW(AW), .XLEN(32)) dut (
    .Clk          (Clk),
    .n_Rst        (n_Rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .mem_we       (mem_we),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Byte-wide data memory: combinational read, synchronous write.
  assign mem_rd = tb_mem[mem_a];
  always @(posedge Clk) begin
    if (mem_fill) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= 8'((i * 37 + 5) & 255);
    end else if (mem_we) begin
      tb_mem[mem_a] <= mem_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'd3) return 1'b1;
    if (addr >= DEPTH) return 1'b1;
    if (addr % size_bytes(sz) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns, input logic [31:0] addr);
    logic [31:0] v;
    int nb;
    nb = size_bytes(sz);
    v = 0;
    for (int i = 0; i < nb; i++) v = v + (32'(ref_mem[(addr + i) % DEPTH]) << (8 * i));
    if (!uns && nb == 1 && v >= 128) v = v - 256;
    if (!uns && nb == 2 && v >= 32768) v = v - 65536;
    return v;
  endfunction

  task automatic run_req(input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    bit          err;
    int          nb;
    int          nx;
    logic [31:0] exp_rd;
    err    = model_err(sz, addr);
    nb     = size_bytes(sz);
    nx     = err ? 0 : nb;
    exp_rd = (err || we) ? 32'h0 : model_load(sz, uns, addr);

    @(negedge Clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    check("idle_ready", 32'(req_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge Clk);

    for (int k = 1; k <= nx + 1; k++) begin
      @(negedge Clk);
      check("busy", 32'(busy), 32'd1);
      check("ready_busy", 32'(req_ready), 32'd0);
      if (k <= nx) begin
        check("xfer_rsp_valid", 32'(rsp_valid), 32'd0);
        check("xfer_mem_we", 32'(mem_we), 32'(we));
        check("xfer_mem_a", 32'(mem_a), (addr + k - 1) % DEPTH);
        if (we) check("xfer_mem_wd", 32'(mem_wd), (wd >> (8 * (k - 1))) & 32'hFF);
        if (!hold) begin
          req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
          req_addr = $urandom; req_wdata = $urandom;
        end
      end else begin
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_err", 32'(rsp_err), 32'(err));
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("resp_mem_we", 32'(mem_we), 32'd0);
        if (!hold) req_valid = 1'b0;
      end
    end

    if (!err && we)
      for (int i = 0; i < nb; i++) ref_mem[(addr + i) % DEPTH] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'((i * 37 + 5) & 255);
    n_Rst = 1'b0; mem_fill = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 0; req_wdata = 0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_a", 32'(mem_a), 32'd0);
    check("rst_mem_wd", 32'(mem_wd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge Clk); #1 mem_fill = 1'b0;
    @(negedge Clk); n_Rst = 1'b1;

    // Word store/load round trip.
    run_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
    run_req(0, 2'd2, 0, 32'h10, 32'h0, 0);
    // Byte sign/zero extension.
    run_req(1, 2'd0, 0, 32'h20, 32'h00000080, 0);
    run_req(0, 2'd0, 0, 32'h20, 32'h0, 0);
    run_req(0, 2'd0, 1, 32'h20, 32'h0, 0);
    // Rejected requests.
    run_req(1, 2'd1, 0, 32'h31, 32'h1234, 0);
    run_req(0, 2'd2, 0, 32'h102, 32'h0, 0);
    run_req(0, 2'd3, 0, 32'h08, 32'h0, 0);
    run_req(0, 2'd2, 0, 32'h100, 32'h0, 0);
    // Top-of-memory halfword.
    run_req(1, 2'd1, 0, 32'hFE, 32'h00008001, 0);
    run_req(0, 2'd1, 0, 32'hFE, 32'h0, 0);
    run_req(0, 2'd1, 1, 32'hFE, 32'h0, 0);
    // Back-to-back loads with req_valid held high.
    run_req(0, 2'd2, 0, 32'h10, 32'h0, 1);
    run_req(0, 2'd2, 0, 32'h10, 32'h0, 0);

    // Reset in the middle of a word store.
    @(negedge Clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h11223344;
    @(posedge Clk);
    @(negedge Clk); req_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    n_Rst = 1'b0;
    #1;
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_mem_a", 32'(mem_a), 32'd0);
    check("abort_mem_wd", 32'(mem_wd), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    ref_mem[8'h40] = 8'h44;
    ref_mem[8'h41] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("abort_quiet", 32'(rsp_valid), 32'd0);
    end
    n_Rst = 1'b1;
    run_req(0, 2'd2, 0, 32'h40, 32'h0, 0);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;
      sz = 2'($urandom);
      if (sz == 2'd3 && $urandom_range(0, 2) != 0) sz = 2'd2;
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom;
      else if (r == 1) a = 32'(DEPTH - 4 + $urandom_range(0, 3));
      else a = $urandom_range(0, DEPTH - 1);
      if (r > 2 && sz != 2'd3) a = a & ~32'(size_bytes(sz) - 1);
      run_req(1'($urandom), sz, 1'($urandom), a, $urandom, 0);
    end

    for (int i = 0; i < DEPTH; i++) check("mem_final", 32'(tb_mem[i]), 32'(ref_mem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
